// File: rtl/jtdd_pkg.sv
// Shared definitions for the jtdd video path.
// Contents:
//   CHAR_BASE/OBJ_BASE/SCR_BASE : top two bits of the palette index for each layer
//   COLMIX_LAT                  : colour mixer pipeline depth in pxl_cen steps
//   lyr_pxl_t                   : layer pixel {pal, col}
//   lyr_sel_e                   : which layer won the priority resolution
package jtdd_pkg;

  localparam logic [1:0] CHAR_BASE = 2'b00;
  localparam logic [1:0] OBJ_BASE  = 2'b01;
  localparam logic [1:0] SCR_BASE  = 2'b10;

  localparam int COLMIX_LAT = 3;

  typedef struct packed {
    logic [2:0] pal;
    logic [3:0] col;
  } lyr_pxl_t;

  typedef enum logic [1:0] {
    LYR_CHAR = 2'd0,
    LYR_OBJ  = 2'd1,
    LYR_SCR  = 2'd2,
    LYR_NONE = 2'd3
  } lyr_sel_e;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM, one clock.
// Each port: cen (enables read register and write), addr, data, we, q.
// A port reading the address it is writing sees its own new data (write-first);
// the other port reading the same address in the same cycle sees the old data.
// q registers are cleared by rst_n; the array itself is never cleared.
// Ports:
//   clk, rst_n                 : clock, async active-low reset of the q registers
//   cen0/addr0/data0/we0 -> q0 : port 0
//   cen1/addr1/data1/we1 -> q1 : port 1
module jtframe_dual_ram #(
  parameter int    AW      = 9,
  parameter int    DW      = 8,
  parameter string SIMFILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic          cen1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];

  // Preload images are applied by the simulation harness, not by this RTL.
  if (SIMFILE != "") begin : g_simfile
  end

  always_ff @(posedge clk) begin
    if (cen0 && we0) r_mem[addr0] <= data0;
    if (cen1 && we1) r_mem[addr1] <= data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      if (cen0) q0 <= we0 ? data0 : r_mem[addr0];
      if (cen1) q1 <= we1 ? data1 : r_mem[addr1];
    end
  end

endmodule

// File: rtl/jtdd_colmix.sv
// Colour mixer: resolves char/obj/scroll priority and transparency, looks the
// winning index up in a CPU-writable 512 x 12-bit palette and outputs 4:4:4 RGB
// with blanking delayed to match.
// Ports:
//   clk, rst_n, pxl_cen                 : clock, async active-low reset, pixel enable
//   cpu_AB, pal_cs, cpu_wrn, cpu_dout   : CPU palette access ([9] = 0 RG byte, 1 B byte)
//   pal_dout                            : CPU read data, one clk after the address
//   char_pxl, scr_pxl, obj_pxl          : layer pixels {pal[2:0], col[3:0]}
//   gfx_en                              : layer enables {scr, obj, char}
//   LHBL, LVBL                          : blanking in, active low
//   red, green, blue, LHBL_dly, LVBL_dly: video out, 3 pxl_cen after the inputs
module jtdd_colmix import jtdd_pkg::*; #(
  parameter string SIMFILE_RG = "pal_rg.bin",
  parameter string SIMFILE_B  = "pal_b.bin"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic [9:0] cpu_AB,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [6:0] char_pxl,
  input  logic [6:0] scr_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [2:0] gfx_en,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  lyr_pxl_t w_char, w_obj, w_scr;
  logic     w_char_op, w_obj_op, w_scr_op;
  lyr_sel_e w_sel;
  logic [8:0] w_idx;

  logic       w_we_rg, w_we_b;
  logic [7:0] w_rg_cpu, w_b_cpu, w_rg_vid, w_b_vid;
  logic       w_unused;

  logic [8:0]            r_idx;
  logic [COLMIX_LAT-1:0] r_hbl_sr, r_vbl_sr;
  logic [3:0]            r_red, r_green, r_blue;
  logic                  r_sel_b;

  assign w_char = char_pxl;
  assign w_obj  = obj_pxl;
  assign w_scr  = scr_pxl;

  assign w_char_op = (w_char.col != 4'd0) && gfx_en[0];
  assign w_obj_op  = (w_obj.col  != 4'd0) && gfx_en[1];
  assign w_scr_op  = (w_scr.col  != 4'd0) && gfx_en[2];

  always_comb begin
    w_sel = LYR_NONE;
    if (w_char_op)     w_sel = LYR_CHAR;
    else if (w_obj_op) w_sel = LYR_OBJ;
    else if (w_scr_op) w_sel = LYR_SCR;
  end

  always_comb begin
    w_idx = {SCR_BASE, w_scr.pal, 4'h0};
    case (w_sel)
      LYR_CHAR: w_idx = {CHAR_BASE, w_char};
      LYR_OBJ:  w_idx = {OBJ_BASE,  w_obj};
      LYR_SCR:  w_idx = {SCR_BASE,  w_scr};
      // nothing opaque: scroll palette with its colour 0 acts as background
      default:  w_idx = {SCR_BASE, w_scr.pal, 4'h0};
    endcase
  end

  assign w_we_rg = pal_cs && !cpu_wrn && !cpu_AB[9];
  assign w_we_b  = pal_cs && !cpu_wrn &&  cpu_AB[9];

  // Port 0 runs every clk for the CPU; port 1 only reads, on pxl_cen, so its
  // q register is the S2 stage of the video pipeline.
  jtframe_dual_ram #(.AW(9), .DW(8), .SIMFILE(SIMFILE_RG)) u_ram_rg (
    .clk   (clk),
    .rst_n (rst_n),
    .cen0  (1'b1),
    .addr0 (cpu_AB[8:0]),
    .data0 (cpu_dout),
    .we0   (w_we_rg),
    .q0    (w_rg_cpu),
    .cen1  (pxl_cen),
    .addr1 (r_idx),
    .data1 (8'h00),
    .we1   (1'b0),
    .q1    (w_rg_vid)
  );

  jtframe_dual_ram #(.AW(9), .DW(8), .SIMFILE(SIMFILE_B)) u_ram_b (
    .clk   (clk),
    .rst_n (rst_n),
    .cen0  (1'b1),
    .addr0 (cpu_AB[8:0]),
    .data0 (cpu_dout),
    .we0   (w_we_b),
    .q0    (w_b_cpu),
    .cen1  (pxl_cen),
    .addr1 (r_idx),
    .data1 (8'h00),
    .we1   (1'b0),
    .q1    (w_b_vid)
  );

  // Blanking travels in a shift register: [0] = S1, [1] = S2 (aligned with the
  // palette read data), [LAT-1] = S3 (aligned with RGB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_hbl_sr <= '0;
      r_vbl_sr <= '0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_sel_b  <= 1'b0;
    end else begin
      r_sel_b <= cpu_AB[9];
      if (pxl_cen) begin
        r_idx    <= w_idx;
        r_hbl_sr <= {r_hbl_sr[COLMIX_LAT-2:0], LHBL};
        r_vbl_sr <= {r_vbl_sr[COLMIX_LAT-2:0], LVBL};
        if (r_hbl_sr[COLMIX_LAT-2] && r_vbl_sr[COLMIX_LAT-2]) begin
          r_red   <= w_rg_vid[3:0];
          r_green <= w_rg_vid[7:4];
          r_blue  <= w_b_vid[3:0];
        end else begin
          r_red   <= 4'h0;
          r_green <= 4'h0;
          r_blue  <= 4'h0;
        end
      end
    end
  end

  // The B byte upper nibble only matters to the CPU side.
  assign w_unused = &{1'b0, w_b_vid[7:4]};

  assign pal_dout = r_sel_b ? w_b_cpu : w_rg_cpu;
  assign red      = r_red;
  assign green    = r_green;
  assign blue     = r_blue;
  assign LHBL_dly = r_hbl_sr[COLMIX_LAT-1];
  assign LVBL_dly = r_vbl_sr[COLMIX_LAT-1];

endmodule

// File: tb/tb_jtdd_colmix.sv
module tb_jtdd_colmix;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic [9:0] cpu_AB = '0;
  logic       pal_cs = 1'b0;
  logic       cpu_wrn = 1'b1;
  logic [7:0] cpu_dout = '0;
  logic [7:0] pal_dout;
  logic [6:0] char_pxl = '0, scr_pxl = '0, obj_pxl = '0;
  logic [2:0] gfx_en = 3'b111;
  logic       LHBL = 1'b1, LVBL = 1'b1;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtdd_colmix dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
    .cpu_AB(cpu_AB), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout),
    .pal_dout(pal_dout),
    .char_pxl(char_pxl), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .gfx_en(gfx_en),
    .LHBL(LHBL), .LVBL(LVBL),
    .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  // reference palette
  logic [7:0] m_rg [512];
  logic [7:0] m_b  [512];

  typedef struct {
    int         tgt;
    logic [3:0] r, g, b;
    logic       h, v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   cen_cnt = 0;

  // pixel whose palette read is still ahead
  bit         have_prev = 0;
  logic [8:0] p_idx;
  logic       p_h, p_v;
  int         p_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Highest priority opaque layer wins; nothing opaque -> scroll palette, colour 0.
  function automatic logic [8:0] ref_index(input logic [6:0] c, input logic [6:0] o,
                                           input logic [6:0] s, input logic [2:0] g);
    if (g[0] && c[3:0] != 4'd0) return {2'b00, c};
    if (g[1] && o[3:0] != 4'd0) return {2'b01, o};
    if (g[2] && s[3:0] != 4'd0) return {2'b10, s};
    return {2'b10, s[6:4], 4'h0};
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [7:0] d);
    if (a[9]) m_b[a[8:0]] = d;
    else      m_rg[a[8:0]] = d;
  endtask

  task automatic push_prev();
    exp_t e;
    if (have_prev) begin
      e.tgt = p_tgt;
      e.h = p_h;
      e.v = p_v;
      if (p_h && p_v) begin
        e.r = m_rg[p_idx][3:0];
        e.g = m_rg[p_idx][7:4];
        e.b = m_b[p_idx][3:0];
      end else begin
        e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
      end
      sb.push_back(e);
    end
  endtask

  // After reset the first two pxl_cen produce blanked output.
  task automatic after_reset();
    exp_t e;
    sb.delete();
    have_prev = 0;
    for (int k = 1; k <= 2; k++) begin
      e.tgt = cen_cnt + k;
      e.r = 4'h0; e.g = 4'h0; e.b = 4'h0; e.h = 1'b0; e.v = 1'b0;
      sb.push_back(e);
    end
  endtask

  // One pixel: a pxl_cen-low clk (optional CPU write), then a pxl_cen-high clk
  // sampling the pixel (optional CPU write colliding with the video read).
  // Starts and ends at a negedge.
  task automatic step(input logic [6:0] c, input logic [6:0] o, input logic [6:0] s,
                      input logic [2:0] g, input logic h, input logic v,
                      input bit wr, input bit wr_cen, input logic [9:0] wa, input logic [7:0] wd);
    pxl_cen = 1'b0;
    if (wr && !wr_cen) begin
      pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = wa; cpu_dout = wd;
    end else begin
      pal_cs = 1'b0; cpu_wrn = 1'b1;
    end
    @(posedge clk);
    if (wr && !wr_cen) model_write(wa, wd);
    @(negedge clk);
    pxl_cen = 1'b1;
    char_pxl = c; obj_pxl = o; scr_pxl = s; gfx_en = g; LHBL = h; LVBL = v;
    if (wr && wr_cen) begin
      pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = wa; cpu_dout = wd;
    end else begin
      pal_cs = 1'b0; cpu_wrn = 1'b1;
    end
    push_prev();
    if (wr && wr_cen) model_write(wa, wd);
    p_idx = ref_index(c, o, s, g);
    p_h = h; p_v = v;
    p_tgt = cen_cnt + 3;
    have_prev = 1;
    @(posedge clk);
    @(negedge clk);
    pxl_cen = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1;
  endtask

  task automatic pix(input logic [6:0] c, input logic [6:0] o, input logic [6:0] s,
                     input logic [2:0] g, input logic h, input logic v);
    step(c, o, s, g, h, v, 0, 0, 10'h0, 8'h0);
  endtask

  task automatic hold_check(input string name, input logic [6:0] c, input logic [6:0] o,
                            input logic [6:0] s, input logic [2:0] g,
                            input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    repeat (3) pix(c, o, s, g, 1'b1, 1'b1);
    chk({name, "_red"},   red,   er);
    chk({name, "_green"}, green, eg);
    chk({name, "_blue"},  blue,  eb);
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
    pxl_cen = 1'b0;
    pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = a; cpu_dout = d;
    @(posedge clk);
    model_write(a, d);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wrn = 1'b1;
  endtask

  task automatic cpu_read_check(input string name, input logic [9:0] a);
    logic [7:0] e;
    e = a[9] ? m_b[a[8:0]] : m_rg[a[8:0]];
    pxl_cen = 1'b0;
    pal_cs = 1'b1; cpu_wrn = 1'b1; cpu_AB = a;
    @(posedge clk);
    #1 chk(name, pal_dout, e);
    @(negedge clk);
    pal_cs = 1'b0;
  endtask

  function automatic logic [6:0] rnd_pxl();
    logic [6:0] p;
    p = 7'($urandom);
    if ($urandom_range(0, 2) == 0) p[3:0] = 4'h0;
    return p;
  endfunction

  task automatic rnd_steps(input int n);
    logic [2:0] g;
    for (int i = 0; i < n; i++) begin
      g = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      step(rnd_pxl(), rnd_pxl(), rnd_pxl(), g,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           10'($urandom), 8'($urandom));
    end
  endtask

  // monitor: one expected entry per pxl_cen edge once the pipeline is full
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && pxl_cen) begin
        cen_cnt++;
        #1;
        while (sb.size() > 0 && sb[0].tgt < cen_cnt) begin
          checks++;
          errors++;
          $display("FAIL sb_missed: entry for pxl_cen %0d not compared, now %0d", sb[0].tgt, cen_cnt);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].tgt == cen_cnt) begin
          mon_e = sb.pop_front();
          chk("pix_red",   red,      mon_e.r);
          chk("pix_green", green,    mon_e.g);
          chk("pix_blue",  blue,     mon_e.b);
          chk("pix_lhbl",  LHBL_dly, mon_e.h);
          chk("pix_lvbl",  LVBL_dly, mon_e.v);
          last_exp = mon_e;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    after_reset();

    for (int a = 0; a < 1024; a++) cpu_write(10'(a), 8'($urandom));
    for (int i = 0; i < 4; i++) cpu_read_check("cpu_rd_rand", 10'($urandom));

    // priority
    cpu_write(10'h015, 8'h3A); cpu_write(10'h215, 8'h05);
    cpu_write(10'h095, 8'hFF); cpu_write(10'h295, 8'h0F);
    hold_check("prio_char", 7'h15, 7'h15, 7'h00, 3'b111, 4'hA, 4'h3, 4'h5);
    hold_check("prio_obj",  7'h10, 7'h15, 7'h00, 3'b111, 4'hF, 4'hF, 4'hF);

    // all transparent
    cpu_write(10'h170, 8'h21); cpu_write(10'h370, 8'h04);
    hold_check("all_transp", 7'h70, 7'h70, 7'h70, 3'b111, 4'h1, 4'h2, 4'h4);

    // debug masking
    hold_check("gfx_mask", 7'h15, 7'h15, 7'h00, 3'b110, 4'hF, 4'hF, 4'hF);

    // collision: write lands on the same clk as the video read of 0x015
    pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);
    step(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1, 1, 1, 10'h015, 8'h5C);
    pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);
    chk("collide_old_red", red, 4'hA);
    pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);
    chk("collide_new_red", red, 4'hC);
    chk("collide_new_green", green, 4'h5);

    // blanking pulses
    for (int i = 0; i < 8; i++) pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);

    // CPU access, including write-first readback
    cpu_write(10'h3FF, 8'hC7);
    cpu_read_check("cpu_rd_b1ff", 10'h3FF);
    pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = 10'h0FF; cpu_dout = 8'h6B;
    @(posedge clk);
    model_write(10'h0FF, 8'h6B);
    #1 chk("cpu_wr_first", pal_dout, 8'h6B);
    @(negedge clk);
    pal_cs = 1'b0; cpu_wrn = 1'b1;

    // pxl_cen held low: outputs hold while CPU traffic continues
    pix(7'h15, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);
    char_pxl = 7'h33; LHBL = 1'b0;
    for (int i = 0; i < 6; i++) cpu_write(10'(10'h180 + i), 8'($urandom));
    chk("hold_red",   red,      last_exp.r);
    chk("hold_green", green,    last_exp.g);
    chk("hold_blue",  blue,     last_exp.b);
    chk("hold_lhbl",  LHBL_dly, last_exp.h);
    cpu_read_check("cpu_rd_hold", 10'h182);

    rnd_steps(300);

    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    chk("rst_red",   red,      4'h0);
    chk("rst_green", green,    4'h0);
    chk("rst_blue",  blue,     4'h0);
    chk("rst_lhbl",  LHBL_dly, 1'b0);
    chk("rst_lvbl",  LVBL_dly, 1'b0);
    chk("rst_dout",  pal_dout, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    after_reset();
    rnd_steps(100);

    // drain the scoreboard
    pix(7'h00, 7'h00, 7'h00, 3'b111, 1'b1, 1'b1);
    have_prev = 0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      pxl_cen = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pxl_cen = 1'b0;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
